// File: rtl/max_pool_stream.sv
// Streaming POOL x POOL max-pooling (stride POOL) for one channel, raster-order input.
// Define MAX_POOL_RELU_EN to clamp negative pooled results to zero (fused ReLU).
module max_pool_stream #(
    parameter int DATA_W = 22,
    parameter int POOL   = 2,
    parameter int IMG_W  = 24,
    parameter int IMG_H  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              frame_done
);

    localparam int NWIN = IMG_W / POOL;
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int PW   = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int WCW  = (NWIN > 1) ? $clog2(NWIN) : 1;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [PW-1:0]     win_r;
    logic [PW-1:0]     cc;
    logic [WCW-1:0]    win_c;
    logic [DATA_W-1:0] acc [NWIN];

    logic              accept;
    logic              transfer;
    logic              win_start;
    logic              last_pix;
    logic              col_end;
    logic              frame_end;
    logic [DATA_W-1:0] acc_cur;
    logic [DATA_W-1:0] pool_max;
    logic [DATA_W-1:0] emit_val;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    assign win_start = (win_r == '0) && (cc == '0);
    assign last_pix  = (win_r == PW'(POOL - 1)) && (cc == PW'(POOL - 1));
    assign col_end   = (col == CW'(IMG_W - 1));
    assign frame_end = (row == RW'(IMG_H - 1)) && col_end;

    // Ties keep the stored value, so only a strictly larger pixel replaces it.
    assign acc_cur  = acc[win_c];
    assign pool_max = ($signed(in_data) > $signed(acc_cur)) ? in_data : acc_cur;

`ifdef MAX_POOL_RELU_EN
    assign emit_val = pool_max[DATA_W-1] ? '0 : pool_max;
`else
    assign emit_val = pool_max;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            win_r <= '0;
            cc    <= '0;
            win_c <= '0;
        end else if (accept) begin
            if (col_end) begin
                col   <= '0;
                cc    <= '0;
                win_c <= '0;
                if (row == RW'(IMG_H - 1)) begin
                    row   <= '0;
                    win_r <= '0;
                end else begin
                    row   <= row + 1'b1;
                    win_r <= (win_r == PW'(POOL - 1)) ? '0 : win_r + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
                if (cc == PW'(POOL - 1)) begin
                    cc    <= '0;
                    win_c <= win_c + 1'b1;
                end else begin
                    cc <= cc + 1'b1;
                end
            end
        end
    end

    // Accumulators need no reset: each one is overwritten by its window's first pixel.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc[win_c] <= win_start ? in_data : pool_max;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            frame_done <= 1'b0;
        end else if (accept && last_pix) begin
            out_valid  <= 1'b1;
            out_data   <= emit_val;
            frame_done <= frame_end;
        end else if (transfer) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_max_pool_stream.sv
// Scoreboard bench for max_pool_stream: a 2x2 (4x2 map) and a 3x3 (6x3 map) instance.
// The reference model honours MAX_POOL_RELU_EN the same way the design does.
module tb_max_pool_stream;

    typedef struct {
        logic [21:0] data;
        logic        fd;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, frame_done_a;
    logic [21:0] in_data_a, out_data_a;
    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, frame_done_b;
    logic [21:0] in_data_b, out_data_b;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [21:0] frame[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          fd_count_a   = 0;
    int          fd_count_b   = 0;
    int          ready_mode   = 0;
    int          dir_a[8]     = '{1, 5, -3, 7, 2, -8, 9, 0};

    max_pool_stream #(.DATA_W(22), .POOL(2), .IMG_W(4), .IMG_H(2)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
        .frame_done(frame_done_a)
    );

    max_pool_stream #(.DATA_W(22), .POOL(3), .IMG_W(6), .IMG_H(3)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .frame_done(frame_done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: pooled results of the frame in emission order.
    task automatic pushExpected(input int sel, input int p, input int w, input int h);
        logic signed [21:0] m;
        logic signed [21:0] v;
        exp_t e;
        for (int wr = 0; wr < h / p; wr++) begin
            for (int wc = 0; wc < w / p; wc++) begin
                m = frame[(wr * p) * w + wc * p];
                for (int i = 0; i < p; i++) begin
                    for (int j = 0; j < p; j++) begin
                        v = frame[(wr * p + i) * w + wc * p + j];
                        if (v > m) m = v;
                    end
                end
`ifdef MAX_POOL_RELU_EN
                if (m < 0) m = '0;
`endif
                e.data = m;
                e.fd   = (wr == h / p - 1) && (wc == w / p - 1);
                if (sel == 0) exp_a.push_back(e);
                else exp_b.push_back(e);
            end
        end
    endtask

    task automatic sendPixel(input int sel, input logic [21:0] d);
        int waited = 0;
        if (sel == 0) begin
            in_valid_a = 1'b1;
            in_data_a  = d;
        end else begin
            in_valid_b = 1'b1;
            in_data_b  = d;
        end
        @(negedge clk);
        while (((sel == 0) ? in_ready_a : in_ready_b) !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (sel == 0) checkOutput("accept_a", in_ready_a, 1);
        else checkOutput("accept_b", in_ready_b, 1);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic applyStimulus(input int sel, input int gap_max);
        if (sel == 0) pushExpected(0, 2, 4, 2);
        else pushExpected(1, 3, 6, 3);
        for (int k = 0; k < frame.size(); k++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(posedge clk);
                #1;
            end
            sendPixel(sel, frame[k]);
        end
    endtask

    task automatic waitDrain();
        int cycles = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && cycles < 400) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("drain_a", exp_a.size(), 0);
        checkOutput("drain_b", exp_b.size(), 0);
    endtask

    task automatic randomFrame(input int n);
        frame.delete();
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(7, 0) == 0) frame.push_back(22'h200000);
            else frame.push_back(22'($urandom));
        end
    endtask

    initial begin
        out_ready_a = 1'b1;
        out_ready_b = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: begin out_ready_a = 1'b1; out_ready_b = 1'b1; end
                1: begin out_ready_a = 1'($urandom); out_ready_b = 1'($urandom); end
                default: begin out_ready_a = 1'b0; out_ready_b = 1'b0; end
            endcase
        end
    end

    // Output is compared against the queue head whenever valid; popped on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid_a === 1'b1) begin
                if (exp_a.size() == 0) checkOutput("extra_out_a", out_valid_a, 0);
                else begin
                    checkOutput("data_a", out_data_a, exp_a[0].data);
                    checkOutput("fd_a", frame_done_a, exp_a[0].fd);
                    if (out_ready_a) begin
                        if (frame_done_a) fd_count_a++;
                        void'(exp_a.pop_front());
                    end
                end
            end
            if (out_valid_b === 1'b1) begin
                if (exp_b.size() == 0) checkOutput("extra_out_b", out_valid_b, 0);
                else begin
                    checkOutput("data_b", out_data_b, exp_b[0].data);
                    checkOutput("fd_b", frame_done_b, exp_b[0].fd);
                    if (out_ready_b) begin
                        if (frame_done_b) fd_count_b++;
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int fd_base;
        reset      = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_data_a  = '0;
        in_data_b  = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid_a", out_valid_a, 0);
        checkOutput("rst_out_data_a", out_data_a, 0);
        checkOutput("rst_frame_done_a", frame_done_a, 0);
        checkOutput("rst_in_ready_a", in_ready_a, 1);
        checkOutput("rst_out_valid_b", out_valid_b, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed 2x2 frame");
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(22'(dir_a[i]));
        pushExpected(0, 2, 4, 2);
        for (int i = 0; i < 8; i++) begin
            sendPixel(0, frame[i]);
            if (i == 4) checkOutput("lat_idle_a", out_valid_a, 0);
            if (i == 5) checkOutput("lat_win0_a", out_valid_a, 1);
            if (i == 6) checkOutput("lat_gap_a", out_valid_a, 0);
            if (i == 7) checkOutput("lat_win1_fd_a", {out_valid_a, frame_done_a}, 2'b11);
        end
        waitDrain();

        $display("[TB] most-negative frame");
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(22'h200000);
        applyStimulus(0, 0);
        waitDrain();

        $display("[TB] backpressure hold");
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(22'(dir_a[i]));
        pushExpected(0, 2, 4, 2);
        ready_mode = 2;
        for (int i = 0; i < 6; i++) sendPixel(0, frame[i]);
        in_valid_a = 1'b1;
        in_data_a  = frame[6];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("hold_in_ready_a", in_ready_a, 0);
            checkOutput("hold_out_valid_a", out_valid_a, 1);
            checkOutput("hold_out_data_a", out_data_a, 5);
        end
        @(posedge clk);
        #1;
        ready_mode = 0;
        sendPixel(0, frame[6]);
        sendPixel(0, frame[7]);
        waitDrain();

        $display("[TB] directed 3x3 frame");
        frame.delete();
        for (int i = 0; i < 18; i++) frame.push_back(22'(i));
        applyStimulus(1, 0);
        checkOutput("fd_win1_b", {out_valid_b, frame_done_b, out_data_b}, {2'b11, 22'd17});
        waitDrain();

        $display("[TB] reset mid-frame");
        for (int i = 0; i < 3; i++) sendPixel(0, 22'd1000 + 22'(i));
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("midrst_out_valid_a", out_valid_a, 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        frame.delete();
        for (int i = 0; i < 8; i++) frame.push_back(22'(dir_a[7 - i] * 3));
        applyStimulus(0, 0);
        waitDrain();

        $display("[TB] random gaps, 4 frames");
        ready_mode = 1;
        fd_base = fd_count_a;
        for (int f = 0; f < 4; f++) begin
            randomFrame(8);
            applyStimulus(0, 2);
        end
        for (int f = 0; f < 2; f++) begin
            randomFrame(18);
            applyStimulus(1, 2);
        end
        waitDrain();
        checkOutput("fd_count_a", fd_count_a - fd_base, 4);
        checkOutput("fd_count_b", fd_count_b, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
